// File: rtl/vote_tally_scheduler_if.sv
// rtl/vote_tally_scheduler_if.sv - vote_processor handshake bundle for the tally scheduler
//
// Signals:
//   vote_written_in      one vote stored in the vote_processor buffer
//   request_new_vote_out one-cycle read request to the vote_processor
//   vote_in              decoded vote value (1 = yes, 0 = no)
//   valid_vote_in        vote_in is valid this cycle
// Modports:
//   master - the scheduler (issues requests, consumes votes)
//   slave  - the vote_processor side
interface vote_tally_scheduler_if;
    logic vote_written_in;
    logic request_new_vote_out;
    logic vote_in;
    logic valid_vote_in;

    modport master (
        output request_new_vote_out,
        input  vote_written_in,
        input  vote_in,
        input  valid_vote_in
    );

    modport slave (
        input  request_new_vote_out,
        output vote_written_in,
        output vote_in,
        output valid_vote_in
    );
endinterface

// File: rtl/vote_tally_scheduler.sv
// rtl/vote_tally_scheduler.sv - sequences vote_processor reads and tallies yes/no votes
//
// Ports:
//   clk_in         system clock
//   rst_in         asynchronous active-low reset
//   start_in       begin a tally session (1-cycle pulse)
//   close_in       poll closed: drain remaining votes, then finish (1-cycle pulse)
//   vif            vote_processor handshake (master side)
//   yes_count_out  yes votes tallied
//   no_count_out   no votes tallied
//   pending_out    votes written but not yet requested
//   busy_out       session active (COLLECT/WAIT/DRAIN)
//   done_out       tally final
//   error_out      timeout, spurious valid or pending overflow
module vote_tally_scheduler #(
    parameter int MAX_VOTES      = 10000,
    parameter int VOTE_LATENCY   = 2,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             start_in,
    input  logic                             close_in,
    vote_tally_scheduler_if.master           vif,
    output logic [$clog2(MAX_VOTES+1)-1:0]   yes_count_out,
    output logic [$clog2(MAX_VOTES+1)-1:0]   no_count_out,
    output logic [$clog2(MAX_VOTES+1)-1:0]   pending_out,
    output logic                             busy_out,
    output logic                             done_out,
    output logic                             error_out
);

    localparam int CW = $clog2(MAX_VOTES + 1);
    // A timeout at or below the read latency would fire on every healthy read,
    // so the effective timeout is clamped just above the latency.
    localparam int TO = (TIMEOUT_CYCLES > VOTE_LATENCY) ? TIMEOUT_CYCLES : VOTE_LATENCY + 1;
    localparam int TW = $clog2(TO + 1);
    localparam logic [CW-1:0] MAXV = CW'(MAX_VOTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WAIT,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [TW-1:0] timer;
    logic          close_latch;
    logic          issue;
    logic          accept;
    logic          clr_tally;
    logic          overflow;
    logic          spurious;

    always_comb begin
        next_state = state;
        issue      = 1'b0;
        accept     = 1'b0;
        clr_tally  = 1'b0;

        // A write that coincides with a request pulse nets to zero, so only
        // an unmatched write at full depth overflows.
        overflow = vif.vote_written_in && !vif.request_new_vote_out && (pending_out == MAXV);
        spurious = vif.valid_vote_in && (state != S_WAIT);

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_in) begin
                    clr_tally  = 1'b1;
                    next_state = S_COLLECT;
                end
            end
            S_COLLECT, S_DRAIN: begin
                if (pending_out != '0) begin
                    issue      = 1'b1;
                    next_state = S_WAIT;
                end else if (state == S_DRAIN) begin
                    next_state = S_DONE;
                end else if (close_in) begin
                    next_state = S_DRAIN;
                end
            end
            S_WAIT: begin
                if (vif.valid_vote_in) begin
                    accept     = 1'b1;
                    next_state = (close_latch || close_in) ? S_DRAIN : S_COLLECT;
                end else if (timer == TW'(TO - 1)) begin
                    next_state = S_ERR;
                end
            end
            default: next_state = S_IDLE;
        endcase

        // Error conditions pre-empt whatever the state wanted to do this cycle.
        if (overflow || spurious) begin
            next_state = S_ERR;
            issue      = 1'b0;
            accept     = 1'b0;
            clr_tally  = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state                    <= S_IDLE;
            vif.request_new_vote_out <= 1'b0;
            pending_out              <= '0;
            timer                    <= '0;
            close_latch              <= 1'b0;
            yes_count_out            <= '0;
            no_count_out             <= '0;
            busy_out                 <= 1'b0;
            done_out                 <= 1'b0;
            error_out                <= 1'b0;
        end else begin
            state                    <= next_state;
            vif.request_new_vote_out <= issue;

            // The vote leaves the pending count in the cycle the request pulse is visible.
            if (!overflow) begin
                if (vif.vote_written_in && !vif.request_new_vote_out)
                    pending_out <= pending_out + CW'(1);
                else if (!vif.vote_written_in && vif.request_new_vote_out)
                    pending_out <= pending_out - CW'(1);
            end

            if (state == S_WAIT && next_state == S_WAIT)
                timer <= timer + TW'(1);
            else
                timer <= '0;

            if (clr_tally)
                close_latch <= 1'b0;
            else if (close_in && (state == S_COLLECT || state == S_WAIT))
                close_latch <= 1'b1;

            if (clr_tally) begin
                yes_count_out <= '0;
                no_count_out  <= '0;
            end else if (accept) begin
                if (vif.vote_in && yes_count_out != MAXV)
                    yes_count_out <= yes_count_out + CW'(1);
                else if (!vif.vote_in && no_count_out != MAXV)
                    no_count_out <= no_count_out + CW'(1);
            end

            busy_out  <= (next_state == S_COLLECT) || (next_state == S_WAIT) || (next_state == S_DRAIN);
            done_out  <= (next_state == S_DONE);
            error_out <= (next_state == S_ERR);
        end
    end

endmodule

// File: tb/tb_vote_tally_scheduler.sv
// tb/tb_vote_tally_scheduler.sv - self-checking bench for vote_tally_scheduler
module tb_vote_tally_scheduler;

    localparam int MAXV = 10000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        close = 1'b0;
    logic [13:0] yes_c;
    logic [13:0] no_c;
    logic [13:0] pend;
    logic        busy;
    logic        done;
    logic        err;

    vote_tally_scheduler_if vif();

    vote_tally_scheduler #(
        .MAX_VOTES(MAXV),
        .VOTE_LATENCY(2),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .start_in(start),
        .close_in(close),
        .vif(vif),
        .yes_count_out(yes_c),
        .no_count_out(no_c),
        .pending_out(pend),
        .busy_out(busy),
        .done_out(done),
        .error_out(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_req = -100;
    bit resp_en = 1'b1;
    bit spur = 1'b0;
    bit r1 = 1'b0;
    bit r2 = 1'b0;
    bit vote_q[$];
    int exp_q[$];

    typedef struct {
        int         n;
        logic [7:0] bits;
        bit         close_in_wait;
        int         exp_yes;
        int         exp_no;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Model of the vote_processor read port: a request seen in cycle t returns
    // the oldest stored vote during cycle t+2.
    initial begin
        bit v;
        vif.vote_in = 1'b0;
        vif.valid_vote_in = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                r1 = 1'b0;
                r2 = 1'b0;
                last_req = -100;
                vif.valid_vote_in = spur;
            end else begin
                v = r2 && resp_en;
                vif.valid_vote_in = v || spur;
                if (v) begin
                    chk("vote_model_has_vote", int'(vote_q.size() > 0), 1);
                    if (vote_q.size() > 0) vif.vote_in = vote_q.pop_front();
                end
                r2 = r1;
                r1 = vif.request_new_vote_out;
                if (vif.request_new_vote_out) begin
                    chk("req_spacing_ge3", int'(cyc - last_req >= 3), 1);
                    last_req = cyc;
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_close();
        close = 1'b1;
        tick();
        close = 1'b0;
    endtask

    task automatic write_vote(input bit b);
        vote_q.push_back(b);
        vif.vote_written_in = 1'b1;
        tick();
        vif.vote_written_in = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (vif.request_new_vote_out) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("req_seen", int'(ok), 1);
    endtask

    task automatic wait_done_and_score(input string nm);
        bit ok;
        int ey;
        int en;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({nm, "_done"}, int'(ok), 1);
        ey = exp_q.pop_front();
        en = exp_q.pop_front();
        chk({nm, "_yes"}, int'(yes_c), ey);
        chk({nm, "_no"}, int'(no_c), en);
        chk({nm, "_pending"}, int'(pend), 0);
        chk({nm, "_busy"}, int'(busy), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        bit ok;
        vif.vote_written_in = 1'b0;

        vecs[0] = '{3, 8'b0000_0101, 1'b0, 2, 1};
        vecs[1] = '{4, 8'b0000_0110, 1'b1, 2, 2};
        vecs[2] = '{5, 8'b0000_0000, 1'b1, 0, 5};
        vecs[3] = '{8, 8'b1111_1111, 1'b0, 8, 0};
        vecs[4] = '{1, 8'b0000_0001, 1'b0, 1, 0};
        vecs[5] = '{0, 8'b0000_0000, 1'b0, 0, 0};
        vecs[6] = '{6, 8'b0010_1101, 1'b1, 4, 2};

        // Reset state
        tick();
        chk("rst_yes", int'(yes_c), 0);
        chk("rst_no", int'(no_c), 0);
        chk("rst_pending", int'(pend), 0);
        chk("rst_req", int'(vif.request_new_vote_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(err), 0);
        rst_n = 1'b1;
        tick();

        // Request-to-count latency, then write coinciding with a request
        pulse_start();
        chk("start_busy", int'(busy), 1);
        exp_q.push_back(2);
        exp_q.push_back(1);
        write_vote(1'b1);
        wait_req(ok);
        chk("lat_pending_at_req", int'(pend), 1);
        tick();
        chk("lat_req_t1", int'(vif.request_new_vote_out), 0);
        tick();
        chk("lat_req_t2", int'(vif.request_new_vote_out), 0);
        chk("lat_yes_t2", int'(yes_c), 0);
        tick();
        chk("lat_yes_t3", int'(yes_c), 1);
        write_vote(1'b0);
        wait_req(ok);
        chk("same_cyc_pending_before", int'(pend), 1);
        write_vote(1'b1);
        chk("same_cyc_pending_after", int'(pend), 1);
        pulse_close();
        wait_done_and_score("seq_latency");

        // Table-driven sessions
        for (int k = 0; k < 7; k++) begin
            pulse_start();
            chk($sformatf("vec%0d_cleared", k), int'(yes_c) + int'(no_c), 0);
            exp_q.push_back(vecs[k].exp_yes);
            exp_q.push_back(vecs[k].exp_no);
            for (int i = 0; i < vecs[k].n; i++) write_vote(vecs[k].bits[i]);
            if (vecs[k].close_in_wait) wait_req(ok);
            pulse_close();
            wait_done_and_score($sformatf("vec%0d", k));
        end

        // Frozen outputs in DONE, close ignored
        pulse_close();
        tick();
        chk("done_frozen_done", int'(done), 1);
        chk("done_frozen_yes", int'(yes_c), 4);

        // Timeout: no valid after a request
        pulse_start();
        resp_en = 1'b0;
        write_vote(1'b1);
        wait_req(ok);
        repeat (7) tick();
        chk("timeout_err_t7", int'(err), 0);
        tick();
        chk("timeout_err_t8", int'(err), 1);
        chk("timeout_busy", int'(busy), 0);
        vote_q.delete();
        resp_en = 1'b1;
        repeat (3) tick();
        chk("err_sticky", int'(err), 1);
        pulse_start();
        chk("err_restart_busy", int'(busy), 1);
        chk("err_restart_err", int'(err), 0);
        chk("err_restart_yes", int'(yes_c), 0);
        chk("err_restart_no", int'(no_c), 0);
        exp_q.push_back(0);
        exp_q.push_back(1);
        write_vote(1'b0);
        pulse_close();
        wait_done_and_score("after_err");

        // Pending overflow
        do_reset();
        vif.vote_written_in = 1'b1;
        repeat (MAXV) tick();
        chk("ovf_pending_full", int'(pend), MAXV);
        chk("ovf_err_before", int'(err), 0);
        tick();
        vif.vote_written_in = 1'b0;
        chk("ovf_err", int'(err), 1);
        chk("ovf_pending_held", int'(pend), MAXV);

        // Spurious valid in IDLE
        do_reset();
        chk("spur_err_before", int'(err), 0);
        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("spur_err", int'(err), 1);
        chk("spur_yes", int'(yes_c), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
